// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// No ports; imported by the interface, the lane-merge block and the top.
package regfile_pkg;

    localparam int NUM_REGS    = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int WE_FULL_BIT = 4;
    localparam int NUM_LANES   = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-facing bus of the register file.
//   reg_we     : bit 4 full-word write, bits 3:0 per-lane write enables
//   reg_waddr  : write index        reg_wdata  : write data
//   reg_raddr1 : read port 1 index  reg_rdata1 : read port 1 data
//   reg_raddr2 : read port 2 index  reg_rdata2 : read port 2 data
// master = decode/writeback side, slave = register file.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);

    logic [WE_FULL_BIT:0]  reg_we;
    reg_addr_t             reg_waddr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    reg_addr_t             reg_raddr1;
    reg_addr_t             reg_raddr2;
    logic [DATA_WIDTH-1:0] reg_rdata1;
    logic [DATA_WIDTH-1:0] reg_rdata2;

    modport master (
        output reg_we, reg_waddr, reg_wdata, reg_raddr1, reg_raddr2,
        input  reg_rdata1, reg_rdata2
    );

    modport slave (
        input  reg_we, reg_waddr, reg_wdata, reg_raddr1, reg_raddr2,
        output reg_rdata1, reg_rdata2
    );

endinterface

// File: rtl/regfile_lane_merge.sv
// Combinational write merge: produces the word a register holds after a write.
//   old_word : current register contents
//   wdata    : write data
//   we       : bit 4 full-word write, bits 3:0 per-lane enables
//   merged   : resulting word (old_word when we == 0)
module regfile_lane_merge
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [WE_FULL_BIT:0]  we,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int LANE_W = int'(DATA_WIDTH) / NUM_LANES;

    always_comb begin
        merged = old_word;
        if (we[WE_FULL_BIT]) begin
            // Full-word write overrides whatever the lane bits say.
            merged = wdata;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we[i]) begin
                    merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x DATA_WIDTH integer register file: two combinational read ports with
// write bypass, one synchronous lane-maskable write port, x0 hardwired to 0.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every register
//   bus : register_file_if slave (write port + two read ports)
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    register_file_if.slave  bus
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] merged_w;
    logic                  write_active;

    // Register 0 is never written, so it stays at its reset value of zero.
    assign write_active = !rst && (bus.reg_we != '0) && (bus.reg_waddr != '0);

    regfile_lane_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_merge (
        .old_word (regs_q[bus.reg_waddr]),
        .wdata    (bus.reg_wdata),
        .we       (bus.reg_we),
        .merged   (merged_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_active) begin
            regs_q[bus.reg_waddr] <= merged_w;
        end
    end

    // A bypass hit reads the same register the merge is built from, so the
    // single merged word serves the array update and both read ports.
    always_comb begin
        bus.reg_rdata1 = regs_q[bus.reg_raddr1];
        if (bus.reg_raddr1 == '0) begin
            bus.reg_rdata1 = '0;
        end else if (write_active && (bus.reg_waddr == bus.reg_raddr1)) begin
            bus.reg_rdata1 = merged_w;
        end
    end

    always_comb begin
        bus.reg_rdata2 = regs_q[bus.reg_raddr2];
        if (bus.reg_raddr2 == '0) begin
            bus.reg_rdata2 = '0;
        end else if (write_active && (bus.reg_waddr == bus.reg_raddr2)) begin
            bus.reg_rdata2 = merged_w;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected read data into a
// scoreboard queue, a negedge monitor pops and compares against the read ports.
module tb_register_file;

    logic clk;
    logic rst;

    register_file_if #(.DATA_WIDTH(32)) bus ();

    register_file #(
        .DATA_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge, compare all expectations queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = (e.port == 1) ? bus.reg_rdata1 : bus.reg_rdata2;
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s port%0d: got 0x%08h expected 0x%08h",
                         e.name, e.port, act, e.val);
            end
        end
    end

    task automatic expect_rd(input int port, input logic [31:0] val, input string name);
        exp_t e;
        e.port = port;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic [4:0] ra1,
                         input logic [4:0] ra2);
        bus.reg_we     = we;
        bus.reg_waddr  = waddr;
        bus.reg_wdata  = wdata;
        bus.reg_raddr1 = ra1;
        bus.reg_raddr2 = ra2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(5'b00000, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        rst = 1'b0;

        // Reset state: every register reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            drive(5'b00000, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            expect_rd(1, 32'h0, "reset_rd1");
            expect_rd(2, 32'h0, "reset_rd2");
            step();
        end

        // Full-word write to x10 (bypass visible before the edge).
        drive(5'b10000, 5'd10, 32'h12345678, 5'd10, 5'd5);
        expect_rd(1, 32'h12345678, "full_bypass");
        expect_rd(2, 32'h00000000, "full_other");
        step();
        drive(5'b00000, 5'd10, 32'h12345678, 5'd10, 5'd5);
        expect_rd(1, 32'h12345678, "full_stored");
        expect_rd(2, 32'h00000000, "full_other_stored");
        step();

        // Lanes 0 and 1 into x10.
        drive(5'b00011, 5'd10, 32'hAABBCCDD, 5'd10, 5'd10);
        expect_rd(1, 32'h1234CCDD, "lane01_bypass1");
        expect_rd(2, 32'h1234CCDD, "lane01_bypass2");
        step();
        drive(5'b00000, 5'd10, 32'hAABBCCDD, 5'd10, 5'd0);
        expect_rd(1, 32'h1234CCDD, "lane01_stored");
        step();

        // Single lane 2 into x10.
        drive(5'b00100, 5'd10, 32'h00EE0000, 5'd0, 5'd10);
        expect_rd(2, 32'h12EECCDD, "lane2_bypass");
        step();
        drive(5'b00000, 5'd0, 32'h0, 5'd10, 5'd0);
        expect_rd(1, 32'h12EECCDD, "lane2_stored");
        step();

        // Full bit set overrides lane bits.
        drive(5'b10101, 5'd20, 32'hCAFEF00D, 5'd20, 5'd10);
        expect_rd(1, 32'hCAFEF00D, "fullprio_bypass");
        expect_rd(2, 32'h12EECCDD, "fullprio_other");
        step();
        drive(5'b00000, 5'd0, 32'h0, 5'd20, 5'd20);
        expect_rd(1, 32'hCAFEF00D, "fullprio_stored1");
        expect_rd(2, 32'hCAFEF00D, "fullprio_stored2");
        step();

        // Writes to x0 are ignored, and no bypass applies.
        drive(5'b10000, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_rd(1, 32'h0, "x0_bypass1");
        expect_rd(2, 32'h0, "x0_bypass2");
        step();
        drive(5'b00000, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_rd(1, 32'h0, "x0_stored");
        step();

        // Bypass on both ports to the same register.
        drive(5'b10000, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
        expect_rd(1, 32'hDEADBEEF, "byp7_rd1");
        expect_rd(2, 32'hDEADBEEF, "byp7_rd2");
        step();
        drive(5'b00000, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
        expect_rd(1, 32'hDEADBEEF, "byp7_stored1");
        expect_rd(2, 32'hDEADBEEF, "byp7_stored2");
        step();

        // Lane 3 bypass on port 1 while port 2 reads an unrelated register.
        drive(5'b01000, 5'd7, 32'h11000000, 5'd7, 5'd10);
        expect_rd(1, 32'h11ADBEEF, "lane3_bypass");
        expect_rd(2, 32'h12EECCDD, "lane3_other");
        step();
        drive(5'b00000, 5'd0, 32'h0, 5'd10, 5'd7);
        expect_rd(1, 32'h12EECCDD, "lane3_other_stored");
        expect_rd(2, 32'h11ADBEEF, "lane3_stored");
        step();

        // Reset wins over a simultaneous write.
        rst = 1'b1;
        drive(5'b10000, 5'd3, 32'h00000055, 5'd3, 5'd10);
        step();
        rst = 1'b0;
        drive(5'b00000, 5'd0, 32'h0, 5'd3, 5'd10);
        expect_rd(1, 32'h0, "rstwr_x3");
        expect_rd(2, 32'h0, "rstwr_x10");
        step();
        drive(5'b00000, 5'd0, 32'h0, 5'd7, 5'd20);
        expect_rd(1, 32'h0, "rstwr_x7");
        expect_rd(2, 32'h0, "rstwr_x20");
        step();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry general-purpose register file for the integer core: two combinational read ports and one synchronous write port.
- The write port has lane-granular write enables.
- Register 0 is hardwired to zero.
- Sits between decode (read addresses) and writeback (write address, data and enables).

Parameters:
DATA_WIDTH, 32, width of each register in bits; must be a multiple of 4 (one lane = DATA_WIDTH/4 bits).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
reg_we  input  5  write enable: bit 4 = full-word write; bits 3:0 = per-lane enables (bit i -> lane i)
reg_waddr  input  5  write register index 0..31
reg_wdata  input  DATA_WIDTH  write data
reg_raddr1  input  5  read port 1 register index
reg_raddr2  input  5  read port 2 register index
reg_rdata1  output  DATA_WIDTH  read port 1 data (combinational)
reg_rdata2  output  DATA_WIDTH  read port 2 data (combinational)

Behaviour:
- Storage: 32 registers x DATA_WIDTH bits.
- Reset: rst sampled high at a rising clk edge clears all 32 registers to 0. With all registers zero, both read outputs read 0 after that edge.
- Reset has priority over any simultaneous write; that write is discarded.
- Write: occurs on a rising clk edge with rst low.
  - If reg_we[4]=1, the whole word at reg_waddr takes reg_wdata, regardless of reg_we[3:0].
  - Otherwise, each lane i with reg_we[i]=1 takes reg_wdata lane i. Lanes with reg_we[i]=0 keep their old value.
  - reg_we = 0 means no write.
- Register 0: writes to address 0 are ignored; reads of address 0 always return 0.
- Read: reg_rdataN reflects the register addressed by reg_raddrN combinationally (zero-cycle latency).
- Bypass: if a write is active this cycle, reg_waddr == reg_raddrN, and reg_waddr != 0, then reg_rdataN returns the post-write merged value. This is the old word with the enabled lanes replaced by reg_wdata.
- Both read ports may address the same register, or the write address, in the same cycle. Each port resolves independently.
- Uninitialised inputs (X) before the first reset are not required to produce defined outputs. The bench must reset first.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS = 32
  - REG_ADDR_W = 5
  - WE_FULL_BIT = 4
  - NUM_LANES = 4
  - typedef reg_addr_t (logic [4:0])
- One sub-module, regfile_lane_merge, is natural. It is combinational: old word + wdata + reg_we -> merged word. It is used both for the array update and for the bypass path on each read port.

Test Plan:
- Reset: hold rst=1 for one edge, then read all addresses 0..31 -> rdata1/rdata2 = 0x00000000.
- Full-word write: reg_we=5'b10000, waddr=10, wdata=0x12345678 for one edge, then reg_we=0, raddr1=10, raddr2=5 -> rdata1=0x12345678, rdata2=0x00000000.
- Lane write: after the full-word write above, reg_we=5'b00011, waddr=10, wdata=0xAABBCCDD for one edge -> raddr1=10 returns 0x1234CCDD.
- Register 0: reg_we=5'b10000, waddr=0, wdata=0xFFFFFFFF, then raddr1=0 -> 0x00000000.
- Bypass: with reg_we=5'b10000, waddr=7, wdata=0xDEADBEEF and raddr1=raddr2=7 held before the edge -> both rdata equal 0xDEADBEEF combinationally in the same cycle, and still 0xDEADBEEF after the edge with reg_we=0.
- Reset vs write: rst=1 together with reg_we=5'b10000, waddr=3, wdata=0x55 on one edge -> raddr1=3 returns 0; a register written before the reset also returns 0.
